// File: rtl/io_bus_ctrl.sv
// ---------------------------------------------------------------------------
// io_bus_ctrl
//
// Bridges the 32-bit MicroBlaze MCS IO bus to NUM_SLAVES local peripherals.
// Each CPU request is latched. The controller then drives a one-cycle local
// request strobe, with the chip select held for the whole transaction. It
// waits for the selected slave's ready and answers the CPU with a one-cycle
// mcs_ready. Accesses to unmapped addresses, and slaves that never answer,
// complete with ERR_DATA. Both cases are recorded in sticky error status.
//
// Ports
//   clk, reset        clock and synchronous active-high reset
//   mcs_addr          CPU address; [31:28] selects the slave
//   mcs_wr_enable     one-cycle CPU write strobe
//   mcs_rd_enable     one-cycle CPU read strobe
//   mcs_wr_data       CPU write data
//   mcs_byte_enable   CPU byte enables, forwarded on be_o
//   mcs_ready         one-cycle completion pulse
//   mcs_rd_data       read data; the slave word is replicated to 32 bits
//   addr, rnw, req,   local bus: latched address, read-not-write,
//   wr_data, be_o,    one-cycle request strobe, write data, byte enables,
//   cs                one-hot chip select
//   rd_data, rdy      per-slave read data and ready
//   err_clr           clears the sticky flags and the error count
//   err_unmapped      sticky flag: an unmapped address was accessed
//   err_timeout       sticky flag: a mapped slave never became ready
//   err_cnt           saturating count of error completions
//   err_addr          CPU address of the most recent error completion
// ---------------------------------------------------------------------------
module io_bus_ctrl #(
    parameter int          NUM_SLAVES  = 4,
    parameter logic [3:0]  BASE_NIBBLE = 4'hc,
    parameter int          ADDR_W      = 8,
    parameter int          DATA_W      = 8,
    parameter int          TIMEOUT     = 1023,
    parameter logic [31:0] ERR_DATA    = 32'h0000_0000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [31:0]                  mcs_addr,
    input  logic                         mcs_wr_enable,
    input  logic                         mcs_rd_enable,
    input  logic [31:0]                  mcs_wr_data,
    input  logic [3:0]                   mcs_byte_enable,
    output logic                         mcs_ready,
    output logic [31:0]                  mcs_rd_data,
    output logic [ADDR_W-1:0]            addr,
    output logic                         rnw,
    output logic                         req,
    output logic [DATA_W-1:0]            wr_data,
    output logic [3:0]                   be_o,
    output logic [NUM_SLAVES-1:0]        cs,
    input  logic [NUM_SLAVES*DATA_W-1:0] rd_data,
    input  logic [NUM_SLAVES-1:0]        rdy,
    input  logic                         err_clr,
    output logic                         err_unmapped,
    output logic                         err_timeout,
    output logic [7:0]                   err_cnt,
    output logic [31:0]                  err_addr
);

    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam int              REP      = 32 / DATA_W;

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [CNT_W-1:0]        r_cnt;
    logic [31:0]             r_full_addr;
    logic                    r_ready;
    logic [31:0]             r_rd_data;
    logic [ADDR_W-1:0]       r_addr;
    logic                    r_rnw;
    logic                    r_req;
    logic [DATA_W-1:0]       r_wr_data;
    logic [3:0]              r_be;
    logic [NUM_SLAVES-1:0]   r_cs;
    logic                    r_err_unmapped;
    logic                    r_err_timeout;
    logic [7:0]              r_err_cnt;
    logic [31:0]             r_err_addr;

    logic                    w_accept;
    logic                    w_done_ok;
    logic                    w_err_unm;
    logic                    w_err_to;
    logic                    w_done_err;
    logic                    w_done;
    logic [NUM_SLAVES-1:0]   w_cs_dec;
    logic                    w_sel_rdy;
    logic [DATA_W-1:0]       w_sel_data;
    logic                    w_unused_wr_data;

    // Only the low DATA_W bits of the CPU write data reach the local bus.
    assign w_unused_wr_data = ^mcs_wr_data;

    // Address decode: slave i answers when the top nibble equals
    // BASE_NIBBLE + i. If no slave matches, cs stays zero, and that
    // zero marks the access as unmapped.
    always_comb begin
        w_cs_dec = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (32'(mcs_addr[31:28]) == 32'(BASE_NIBBLE) + 32'(i)) begin
                w_cs_dec[i] = 1'b1;
            end
        end
    end

    // Ready and read data are taken from the selected slave only. Because
    // cs is one-hot, an OR of the masked words acts as the mux.
    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (r_cs[i]) begin
                w_sel_data = w_sel_data | rd_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_sel_rdy = |(rdy & r_cs);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and completion decisions. An unmapped access completes on
    // the first WAIT edge. Slave ready takes priority over the timeout on
    // the last counted edge.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_done_ok    = 1'b0;
        w_err_unm    = 1'b0;
        w_err_to     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (mcs_rd_enable || mcs_wr_enable) begin
                    w_accept     = 1'b1;
                    w_next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cs == '0) begin
                    w_err_unm    = 1'b1;
                    w_next_state = S_IDLE;
                end else if (w_sel_rdy) begin
                    w_done_ok    = 1'b1;
                    w_next_state = S_IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_err_to     = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    assign w_done_err = w_err_unm | w_err_to;
    assign w_done     = w_done_ok | w_done_err;

    // Request latching, the local bus, and the CPU response.
    // The counter holds k-1 at WAIT edge k, so matching TIMEOUT-1 forces
    // completion on edge TIMEOUT. When both strobes are set, the access
    // is treated as a write.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= '0;
            r_full_addr <= '0;
            r_ready     <= 1'b0;
            r_rd_data   <= '0;
            r_addr      <= '0;
            r_rnw       <= 1'b1;
            r_req       <= 1'b0;
            r_wr_data   <= '0;
            r_be        <= '0;
            r_cs        <= '0;
        end else begin
            r_ready <= w_done;
            r_req   <= w_accept;
            if (w_accept) begin
                r_full_addr <= mcs_addr;
                r_addr      <= mcs_addr[ADDR_W-1:0];
                r_wr_data   <= mcs_wr_data[DATA_W-1:0];
                r_be        <= mcs_byte_enable;
                r_rnw       <= ~mcs_wr_enable;
                r_cs        <= w_cs_dec;
                r_cnt       <= '0;
            end else if (r_state == S_WAIT) begin
                if (w_done) begin
                    r_cs <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
            if (w_done_ok && r_rnw) begin
                r_rd_data <= {REP{w_sel_data}};
            end
            if (w_done_err && r_rnw) begin
                r_rd_data <= ERR_DATA;
            end
        end
    end

    // Sticky error status. If an error completes on the same edge as
    // err_clr, the clear is applied first and the new error then lands on
    // top of it. The result is its flag set and a count of one.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_unmapped <= 1'b0;
            r_err_timeout  <= 1'b0;
            r_err_cnt      <= '0;
            r_err_addr     <= '0;
        end else begin
            if (err_clr) begin
                r_err_unmapped <= 1'b0;
                r_err_timeout  <= 1'b0;
                r_err_cnt      <= '0;
            end
            if (w_done_err) begin
                if (w_err_unm) begin
                    r_err_unmapped <= 1'b1;
                end
                if (w_err_to) begin
                    r_err_timeout <= 1'b1;
                end
                if (err_clr) begin
                    r_err_cnt <= 8'd1;
                end else if (r_err_cnt != 8'hff) begin
                    r_err_cnt <= r_err_cnt + 8'd1;
                end
                r_err_addr <= r_full_addr;
            end
        end
    end

    assign mcs_ready    = r_ready;
    assign mcs_rd_data  = r_rd_data;
    assign addr         = r_addr;
    assign rnw          = r_rnw;
    assign req          = r_req;
    assign wr_data      = r_wr_data;
    assign be_o         = r_be;
    assign cs           = r_cs;
    assign err_unmapped = r_err_unmapped;
    assign err_timeout  = r_err_timeout;
    assign err_cnt      = r_err_cnt;
    assign err_addr     = r_err_addr;

endmodule

// File: tb/tb_io_bus_ctrl.sv
// ---------------------------------------------------------------------------
// tb_io_bus_ctrl
//
// Directed bench for io_bus_ctrl. Instance A uses the default 8-bit, four-slave
// configuration with TIMEOUT=16. Instance B uses a 16-bit, two-slave
// configuration. Expected read data is queued when a request is issued and
// compared when the DUT raises mcs_ready.
// ---------------------------------------------------------------------------
module tb_io_bus_ctrl;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    // Instance A signals
    logic [31:0] aAddr, aWrData, aRdDataCpu, aSlaveData, aErrAddr;
    logic        aWrEn, aRdEn, aReady, aRnw, aReq, aErrClr, aErrUnm, aErrTo;
    logic [3:0]  aBe, aBeO, aCs, aRdy;
    logic [7:0]  aLocAddr, aWrDataLoc, aErrCnt;

    // Instance B signals
    logic [31:0] bAddr, bWrData, bRdDataCpu, bSlaveData, bErrAddr;
    logic        bWrEn, bRdEn, bReady, bRnw, bReq, bErrClr, bErrUnm, bErrTo;
    logic [3:0]  bBe, bBeO;
    logic [1:0]  bCs, bRdy;
    logic [7:0]  bLocAddr, bErrCnt;
    logic [15:0] bWrDataLoc;

    int passCount  = 0;
    int failCount  = 0;
    int checkCount = 0;

    logic [31:0] sbQ[$];

    io_bus_ctrl #(.NUM_SLAVES(4), .DATA_W(8), .TIMEOUT(16)) u_dutA (
        .clk(clk), .reset(reset),
        .mcs_addr(aAddr), .mcs_wr_enable(aWrEn), .mcs_rd_enable(aRdEn),
        .mcs_wr_data(aWrData), .mcs_byte_enable(aBe),
        .mcs_ready(aReady), .mcs_rd_data(aRdDataCpu),
        .addr(aLocAddr), .rnw(aRnw), .req(aReq), .wr_data(aWrDataLoc),
        .be_o(aBeO), .cs(aCs), .rd_data(aSlaveData), .rdy(aRdy),
        .err_clr(aErrClr), .err_unmapped(aErrUnm), .err_timeout(aErrTo),
        .err_cnt(aErrCnt), .err_addr(aErrAddr)
    );

    io_bus_ctrl #(.NUM_SLAVES(2), .DATA_W(16), .TIMEOUT(16)) u_dutB (
        .clk(clk), .reset(reset),
        .mcs_addr(bAddr), .mcs_wr_enable(bWrEn), .mcs_rd_enable(bRdEn),
        .mcs_wr_data(bWrData), .mcs_byte_enable(bBe),
        .mcs_ready(bReady), .mcs_rd_data(bRdDataCpu),
        .addr(bLocAddr), .rnw(bRnw), .req(bReq), .wr_data(bWrDataLoc),
        .be_o(bBeO), .cs(bCs), .rd_data(bSlaveData), .rdy(bRdy),
        .err_clr(bErrClr), .err_unmapped(bErrUnm), .err_timeout(bErrTo),
        .err_cnt(bErrCnt), .err_addr(bErrAddr)
    );

    // Single comparison point: counts every check and reports any miss.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Presents a one-cycle CPU strobe and queues the read data expected at
    // completion. Returns just after the edge that accepted the strobe.
    task automatic applyStimulus(input bit useB, input logic [31:0] addrIn,
                                 input bit isWrite, input logic [31:0] wdata,
                                 input logic [3:0] be, input logic [31:0] expRd);
        if (useB) begin
            bAddr = addrIn; bWrData = wdata; bBe = be;
            bWrEn = isWrite; bRdEn = !isWrite;
        end else begin
            aAddr = addrIn; aWrData = wdata; aBe = be;
            aWrEn = isWrite; aRdEn = !isWrite;
        end
        sbQ.push_back(expRd);
        @(posedge clk); #1;
        aWrEn = 1'b0; aRdEn = 1'b0; bWrEn = 1'b0; bRdEn = 1'b0;
    endtask

    // Waits a bounded number of edges for mcs_ready, then checks the
    // latency and the read data against the scoreboard.
    task automatic waitReady(input bit useB, input int maxCycles,
                             input int expCycles, input string tag);
        int cycles = 0;
        bit seen = 1'b0;
        logic [31:0] expRd;
        while (!seen && cycles < maxCycles) begin
            @(posedge clk); #1;
            cycles++;
            seen = useB ? bReady : aReady;
        end
        checkOutput({tag, "_ready"}, 32'(seen), 32'd1);
        checkOutput({tag, "_latency"}, 32'(cycles), 32'(expCycles));
        if (sbQ.size() > 0) begin
            expRd = sbQ.pop_front();
            checkOutput({tag, "_rddata"}, useB ? bRdDataCpu : aRdDataCpu, expRd);
        end else begin
            checkOutput({tag, "_sbempty"}, 32'(sbQ.size()), 32'd1);
        end
    endtask

    initial begin
        bit heldOk;
        bit noReady;
        bit loopReq;
        logic [31:0] dropped;

        reset = 1'b1;
        aAddr = '0; aWrData = '0; aWrEn = 1'b0; aRdEn = 1'b0; aBe = '0;
        aSlaveData = '0; aRdy = '0; aErrClr = 1'b0;
        bAddr = '0; bWrData = '0; bWrEn = 1'b0; bRdEn = 1'b0; bBe = '0;
        bSlaveData = '0; bRdy = '0; bErrClr = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_ready", 32'(aReady), 32'd0);
        checkOutput("rst_rddata", aRdDataCpu, 32'd0);
        checkOutput("rst_addr", 32'(aLocAddr), 32'd0);
        checkOutput("rst_rnw", 32'(aRnw), 32'd1);
        checkOutput("rst_req", 32'(aReq), 32'd0);
        checkOutput("rst_cs", 32'(aCs), 32'd0);
        checkOutput("rst_err", {aErrUnm, aErrTo, aErrCnt, 22'd0}, 32'd0);
        checkOutput("rst_erraddr", aErrAddr, 32'd0);
        reset = 1'b0;

        // Read slave 1, ready on the first WAIT edge
        aSlaveData = {8'hC3, 8'h00, 8'h5A, 8'h00};
        applyStimulus(1'b0, 32'hD000_0012, 1'b0, 32'h0, 4'hF, 32'h5A5A_5A5A);
        checkOutput("rd1_req", 32'(aReq), 32'd1);
        checkOutput("rd1_cs", 32'(aCs), 32'h2);
        checkOutput("rd1_addr", 32'(aLocAddr), 32'h12);
        checkOutput("rd1_rnw", 32'(aRnw), 32'd1);
        aRdy = 4'b0010;
        waitReady(1'b0, 5, 1, "rd1");
        aRdy = 4'b0000;
        checkOutput("rd1_cs_drop", 32'(aCs), 32'd0);
        checkOutput("rd1_req_low", 32'(aReq), 32'd0);
        @(posedge clk); #1;
        checkOutput("rd1_pulse", 32'(aReady), 32'd0);

        // Write slave 0, ready delayed five cycles
        applyStimulus(1'b0, 32'hC000_0003, 1'b1, 32'h0000_00A5, 4'h1, 32'h5A5A_5A5A);
        checkOutput("wr_data", 32'(aWrDataLoc), 32'hA5);
        checkOutput("wr_rnw", 32'(aRnw), 32'd0);
        checkOutput("wr_be", 32'(aBeO), 32'h1);
        checkOutput("wr_cs", 32'(aCs), 32'h1);
        heldOk = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            if (aCs !== 4'b0001 || aReady !== 1'b0 || aReq !== 1'b0) heldOk = 1'b0;
        end
        checkOutput("wr_cs_held", 32'(heldOk), 32'd1);
        aRdy = 4'b0001;
        waitReady(1'b0, 5, 1, "wr");
        aRdy = 4'b0000;
        checkOutput("wr_cs_drop", 32'(aCs), 32'd0);

        // Unmapped read
        applyStimulus(1'b0, 32'h1000_0000, 1'b0, 32'h0, 4'hF, 32'h0000_0000);
        checkOutput("unm_cs", 32'(aCs), 32'd0);
        checkOutput("unm_req", 32'(aReq), 32'd1);
        waitReady(1'b0, 5, 1, "unm");
        checkOutput("unm_flag", 32'(aErrUnm), 32'd1);
        checkOutput("unm_to_flag", 32'(aErrTo), 32'd0);
        checkOutput("unm_cnt", 32'(aErrCnt), 32'd1);
        checkOutput("unm_erraddr", aErrAddr, 32'h1000_0000);

        // Read slave 3 so that the timeout's ERR_DATA is observable
        applyStimulus(1'b0, 32'hF000_0001, 1'b0, 32'h0, 4'hF, 32'hC3C3_C3C3);
        aRdy = 4'b1000;
        waitReady(1'b0, 5, 1, "rd3");

        // Timeout on slave 2 while every other slave signals ready
        applyStimulus(1'b0, 32'hE000_0005, 1'b0, 32'h0, 4'hF, 32'h0000_0000);
        aRdy = 4'b1011;
        waitReady(1'b0, 40, 16, "to1");
        checkOutput("to1_flag", 32'(aErrTo), 32'd1);
        checkOutput("to1_unm_kept", 32'(aErrUnm), 32'd1);
        checkOutput("to1_cnt", 32'(aErrCnt), 32'd2);
        checkOutput("to1_erraddr", aErrAddr, 32'hE000_0005);

        // Back-to-back timeouts, each issued in the cycle mcs_ready is high
        loopReq = 1'b1;
        for (int i = 0; i < 298; i++) begin
            applyStimulus(1'b0, 32'hE000_0005, 1'b0, 32'h0, 4'hF, 32'h0000_0000);
            if (aReq !== 1'b1) loopReq = 1'b0;
            waitReady(1'b0, 40, 16, "to_loop");
        end
        checkOutput("to_loop_req", 32'(loopReq), 32'd1);
        checkOutput("to_sat_cnt", 32'(aErrCnt), 32'd255);

        // err_clr on the same edge as a timeout completion
        applyStimulus(1'b0, 32'hE000_0005, 1'b0, 32'h0, 4'hF, 32'h0000_0000);
        repeat (15) @(posedge clk);
        #1;
        aErrClr = 1'b1;
        waitReady(1'b0, 3, 1, "to_clr");
        aErrClr = 1'b0;
        checkOutput("clr_coinc_cnt", 32'(aErrCnt), 32'd1);
        checkOutput("clr_coinc_to", 32'(aErrTo), 32'd1);
        checkOutput("clr_coinc_unm", 32'(aErrUnm), 32'd0);

        // Plain clear keeps err_addr
        aErrClr = 1'b1;
        @(posedge clk); #1;
        aErrClr = 1'b0;
        checkOutput("clr_cnt", 32'(aErrCnt), 32'd0);
        checkOutput("clr_to", 32'(aErrTo), 32'd0);
        checkOutput("clr_erraddr", aErrAddr, 32'hE000_0005);

        // Reset during WAIT aborts the transaction
        aRdy = 4'b0000;
        applyStimulus(1'b0, 32'hC000_0000, 1'b0, 32'h0, 4'hF, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        dropped = sbQ.pop_front();
        checkOutput("rstw_cs", 32'(aCs), 32'd0);
        checkOutput("rstw_ready", 32'(aReady), 32'd0);
        checkOutput("rstw_rnw", 32'(aRnw), 32'd1);
        checkOutput("rstw_erraddr", aErrAddr, 32'd0);
        aRdy = 4'b0001;
        noReady = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            if (aReady !== 1'b0) noReady = 1'b0;
        end
        checkOutput("rstw_idle", 32'(noReady), 32'd1);
        aSlaveData = {8'h00, 8'h00, 8'h00, 8'h77};
        applyStimulus(1'b0, 32'hC000_0000, 1'b0, 32'h0, 4'hF, 32'h7777_7777);
        waitReady(1'b0, 5, 1, "rstw_rd");
        aRdy = 4'b0000;

        // 16-bit, two-slave instance: ready from the other slave is ignored
        bSlaveData = {16'hBEEF, 16'h1234};
        bRdy = 2'b10;
        applyStimulus(1'b1, 32'hC000_0000, 1'b0, 32'h0, 4'hF, 32'h1234_1234);
        checkOutput("b_cs", 32'(bCs), 32'h1);
        noReady = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            if (bReady !== 1'b0) noReady = 1'b0;
        end
        checkOutput("b_ignore_rdy", 32'(noReady), 32'd1);
        bRdy = 2'b11;
        waitReady(1'b1, 5, 1, "b_rd");
        bRdy = 2'b00;

        // Slave 2 does not exist on the two-slave instance
        applyStimulus(1'b1, 32'hE000_0000, 1'b0, 32'h0, 4'hF, 32'h0000_0000);
        checkOutput("b_unm_cs", 32'(bCs), 32'd0);
        waitReady(1'b1, 5, 1, "b_unm");
        checkOutput("b_unm_flag", 32'(bErrUnm), 32'd1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
